// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C command sequencer: opcodes, FSM states,
// command-word field layout and the read-back word format.
package i2c_seq_pkg;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_ISSUE_W = 3'd3,
        ST_WAIT_W  = 3'd4,
        ST_ISSUE_R = 3'd5,
        ST_WAIT_R  = 3'd6,
        ST_PUSH    = 3'd7
    } seq_state_e;

    localparam int unsigned OP_MSB   = 31;
    localparam int unsigned OP_LSB   = 30;
    localparam int unsigned ADDR_MSB = 15;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_LSB = 0;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } rb_word_t;

    function automatic logic [1:0] cmd_opcode(input logic [31:0] w);
        return w[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [7:0] cmd_addr(input logic [31:0] w);
        return w[ADDR_MSB:ADDR_LSB];
    endfunction

    function automatic logic [7:0] cmd_data(input logic [31:0] w);
        return w[DATA_MSB:DATA_LSB];
    endfunction

endpackage

// File: rtl/i2c_seq_watchdog.sv
// Completion watchdog: cleared before each transfer, counts while waiting,
// flags expiry in the cycle the count reaches TIMEOUT_CYCLES-1.
module i2c_seq_watchdog
    import i2c_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cnt_en,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = cnt_en && (cnt_q == LAST);

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Pops host command words, drives write/read start pulses to the I2C byte
// transmitter, pushes read results to the read-back FIFO and keeps status.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             enable,
    input  logic             itf_sel,
    input  logic             clr_status,
    input  logic [31:0]      cmd_fifo_dout,
    input  logic             cmd_fifo_empty,
    output logic             cmd_fifo_rd_en,
    output logic [7:0]       addr_byte,
    output logic [7:0]       data_byte,
    output logic             WriteByteStart,
    output logic             ReadByteStart,
    input  logic             i2c_w_finish,
    input  logic [7:0]       i2c_rd_data_reg,
    input  logic             i2c_rd_valid_flag,
    output logic [15:0]      rb_fifo_din,
    output logic             rb_fifo_wr_en,
    input  logic             rb_fifo_full,
    output logic             seq_busy,
    output logic [CNT_W-1:0] cmd_count,
    output logic [7:0]       err_count,
    output logic             timeout_err
);

    seq_state_e       state_q, state_d;
    logic             rd_en_q, rd_en_d;
    logic             wstart_q, wstart_d;
    logic             rstart_q, rstart_d;
    logic             wr_en_q, wr_en_d;
    logic             busy_q, busy_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       rd_byte_q, rd_byte_d;
    rb_word_t         rb_din_q, rb_din_d;
    logic [CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             to_err_q, to_err_d;
    logic             wd_clr, wd_en, wd_expire;

    i2c_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (CLK),
        .rst    (rst),
        .clr    (wd_clr),
        .cnt_en (wd_en),
        .expire (wd_expire)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rd_byte_d = rd_byte_q;
        rb_din_d  = rb_din_q;
        cmd_cnt_d = cmd_cnt_q;
        err_cnt_d = err_cnt_q;
        to_err_d  = to_err_q;
        wr_en_d   = 1'b0;
        wd_clr    = 1'b0;
        wd_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && !itf_sel && !cmd_fifo_empty) state_d = ST_FETCH;
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                case (cmd_opcode(cmd_fifo_dout))
                    OP_WRITE: begin
                        addr_d  = cmd_addr(cmd_fifo_dout);
                        data_d  = cmd_data(cmd_fifo_dout);
                        state_d = ST_ISSUE_W;
                    end
                    OP_READ: begin
                        addr_d  = cmd_addr(cmd_fifo_dout);
                        data_d  = '0;
                        state_d = ST_ISSUE_R;
                    end
                    default: begin
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                        state_d = ST_IDLE;
                    end
                endcase
            end
            ST_ISSUE_W: begin
                wd_clr  = 1'b1;
                state_d = ST_WAIT_W;
            end
            ST_WAIT_W: begin
                wd_en = 1'b1;
                // Completion is checked first so it wins over a same-cycle expiry.
                if (i2c_w_finish) begin
                    cmd_cnt_d = cmd_cnt_q + 1'b1;
                    state_d   = ST_IDLE;
                end else if (wd_expire) begin
                    to_err_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_ISSUE_R: begin
                wd_clr  = 1'b1;
                state_d = ST_WAIT_R;
            end
            ST_WAIT_R: begin
                wd_en = 1'b1;
                if (i2c_rd_valid_flag) begin
                    rd_byte_d = i2c_rd_data_reg;
                    state_d   = ST_PUSH;
                end else if (wd_expire) begin
                    to_err_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_PUSH: begin
                if (!rb_fifo_full) begin
                    wr_en_d   = 1'b1;
                    rb_din_d  = '{addr: addr_q, data: rd_byte_q};
                    cmd_cnt_d = cmd_cnt_q + 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clr_status) begin
            cmd_cnt_d = '0;
            err_cnt_d = '0;
            to_err_d  = 1'b0;
        end

        // Strobes are registered from the next state so each is high exactly in that state.
        rd_en_d  = (state_d == ST_FETCH);
        wstart_d = (state_d == ST_ISSUE_W);
        rstart_d = (state_d == ST_ISSUE_R);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rd_en_q   <= 1'b0;
            wstart_q  <= 1'b0;
            rstart_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rd_byte_q <= '0;
            rb_din_q  <= '0;
            cmd_cnt_q <= '0;
            err_cnt_q <= '0;
            to_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            wstart_q  <= wstart_d;
            rstart_q  <= rstart_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rd_byte_q <= rd_byte_d;
            rb_din_q  <= rb_din_d;
            cmd_cnt_q <= cmd_cnt_d;
            err_cnt_q <= err_cnt_d;
            to_err_q  <= to_err_d;
        end
    end

    assign cmd_fifo_rd_en = rd_en_q;
    assign addr_byte      = addr_q;
    assign data_byte      = data_q;
    assign WriteByteStart = wstart_q;
    assign ReadByteStart  = rstart_q;
    assign rb_fifo_din    = rb_din_q;
    assign rb_fifo_wr_en  = wr_en_q;
    assign seq_busy       = busy_q;
    assign cmd_count      = cmd_cnt_q;
    assign err_count      = err_cnt_q;
    assign timeout_err    = to_err_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Scoreboard bench for i2c_cmd_sequencer: directed commands push expected
// start/read-back events; a negedge monitor pops and compares them.
module tb_i2c_cmd_sequencer;

    localparam int unsigned TO = 16;

    logic        CLK = 1'b0;
    logic        rst;
    logic        enable;
    logic        itf_sel;
    logic        clr_status;
    logic [31:0] cmd_fifo_dout = '0;
    logic        cmd_fifo_empty = 1'b1;
    logic        cmd_fifo_rd_en;
    logic [7:0]  addr_byte;
    logic [7:0]  data_byte;
    logic        WriteByteStart;
    logic        ReadByteStart;
    logic        i2c_w_finish;
    logic [7:0]  i2c_rd_data_reg;
    logic        i2c_rd_valid_flag;
    logic [15:0] rb_fifo_din;
    logic        rb_fifo_wr_en;
    logic        rb_fifo_full;
    logic        seq_busy;
    logic [15:0] cmd_count;
    logic [7:0]  err_count;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rd = -100;
    logic prev_full = 1'b0;

    logic [15:0] exp_w[$];
    logic [7:0]  exp_r[$];
    logic [15:0] exp_rb[$];
    logic [31:0] fifo_q[$];

    i2c_cmd_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(16)
    ) dut (
        .CLK               (CLK),
        .rst               (rst),
        .enable            (enable),
        .itf_sel           (itf_sel),
        .clr_status        (clr_status),
        .cmd_fifo_dout     (cmd_fifo_dout),
        .cmd_fifo_empty    (cmd_fifo_empty),
        .cmd_fifo_rd_en    (cmd_fifo_rd_en),
        .addr_byte         (addr_byte),
        .data_byte         (data_byte),
        .WriteByteStart    (WriteByteStart),
        .ReadByteStart     (ReadByteStart),
        .i2c_w_finish      (i2c_w_finish),
        .i2c_rd_data_reg   (i2c_rd_data_reg),
        .i2c_rd_valid_flag (i2c_rd_valid_flag),
        .rb_fifo_din       (rb_fifo_din),
        .rb_fifo_wr_en     (rb_fifo_wr_en),
        .rb_fifo_full      (rb_fifo_full),
        .seq_busy          (seq_busy),
        .cmd_count         (cmd_count),
        .err_count         (err_count),
        .timeout_err       (timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Command FIFO model: pop on rd_en, word presented on the following cycle.
    always @(posedge CLK) begin
        if (cmd_fifo_rd_en && fifo_q.size() > 0) cmd_fifo_dout <= fifo_q.pop_front();
        cmd_fifo_empty <= (fifo_q.size() == 0);
    end

    always @(negedge CLK) begin
        cyc++;
        if (cmd_fifo_rd_en) last_rd = cyc;
        if (WriteByteStart) begin
            if (exp_w.size() == 0) check("unexpected_wstart", WriteByteStart, 0);
            else begin
                check("wstart_bytes", {addr_byte, data_byte}, exp_w.pop_front());
                check("wstart_latency", cyc - last_rd, 2);
            end
        end
        if (ReadByteStart) begin
            if (exp_r.size() == 0) check("unexpected_rstart", ReadByteStart, 0);
            else begin
                check("rstart_bytes", {addr_byte, data_byte}, {exp_r.pop_front(), 8'h00});
                check("rstart_latency", cyc - last_rd, 2);
            end
        end
        if (rb_fifo_wr_en) begin
            check("push_while_full", prev_full, 0);
            if (exp_rb.size() == 0) check("unexpected_push", rb_fifo_wr_en, 0);
            else check("rb_din", rb_fifo_din, exp_rb.pop_front());
        end
        prev_full = rb_fifo_full;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_sig(input int which, input int maxc, input string name);
        int n = 0;
        logic hit = 1'b0;
        while (!hit && n < maxc) begin
            tick();
            n++;
            case (which)
                0: hit = WriteByteStart;
                1: hit = ReadByteStart;
                2: hit = !seq_busy;
                default: hit = rb_fifo_wr_en;
            endcase
        end
        check({name, "_seen"}, hit, 1);
    endtask

    task automatic pulse_finish();
        i2c_w_finish = 1'b1;
        tick();
        i2c_w_finish = 1'b0;
    endtask

    task automatic pulse_rd(input logic [7:0] d);
        i2c_rd_data_reg   = d;
        i2c_rd_valid_flag = 1'b1;
        tick();
        i2c_rd_valid_flag = 1'b0;
    endtask

    task automatic clear_status();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; itf_sel = 1'b0; clr_status = 1'b0;
        i2c_w_finish = 1'b0; i2c_rd_data_reg = '0; i2c_rd_valid_flag = 1'b0;
        rb_fifo_full = 1'b0;
        repeat (3) tick();
        check("rst_rd_en", cmd_fifo_rd_en, 0);
        check("rst_wstart", WriteByteStart, 0);
        check("rst_rstart", ReadByteStart, 0);
        check("rst_addr", addr_byte, 0);
        check("rst_data", data_byte, 0);
        check("rst_rb_din", rb_fifo_din, 0);
        check("rst_wr_en", rb_fifo_wr_en, 0);
        check("rst_busy", seq_busy, 0);
        check("rst_cmd_count", cmd_count, 0);
        check("rst_err_count", err_count, 0);
        check("rst_timeout", timeout_err, 0);
        rst = 1'b0;
        tick();

        // Basic write
        fifo_q.push_back(32'h4000_1A5C);
        exp_w.push_back(16'h1A5C);
        wait_sig(0, 20, "t1_wstart");
        tick(); tick();
        pulse_finish();
        check("t1_busy", seq_busy, 0);
        check("t1_cmd_count", cmd_count, 1);
        check("t1_addr_hold", {addr_byte, data_byte}, 16'h1A5C);
        clear_status();
        check("t1_clr_cmd", cmd_count, 0);

        // Basic read
        fifo_q.push_back(32'h8000_2300);
        exp_r.push_back(8'h23);
        exp_rb.push_back(16'h23C3);
        wait_sig(1, 20, "t2_rstart");
        tick();
        pulse_rd(8'hC3);
        wait_sig(3, 5, "t2_push");
        check("t2_cmd_count", cmd_count, 1);
        check("t2_busy", seq_busy, 0);

        // Read-back FIFO full for 10 cycles
        clear_status();
        rb_fifo_full = 1'b1;
        fifo_q.push_back(32'h8000_4455);
        exp_r.push_back(8'h44);
        exp_rb.push_back(16'h4477);
        wait_sig(1, 20, "t3_rstart");
        tick();
        pulse_rd(8'h77);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_no_push", rb_fifo_wr_en, 0);
        end
        check("t3_busy_hold", seq_busy, 1);
        rb_fifo_full = 1'b0;
        tick();
        check("t3_push_edge", rb_fifo_wr_en, 1);
        check("t3_cmd_count", cmd_count, 1);

        // Illegal opcode followed by a write
        clear_status();
        fifo_q.push_back(32'hC000_0000);
        fifo_q.push_back(32'h4000_0102);
        exp_w.push_back(16'h0102);
        wait_sig(0, 30, "t4_wstart");
        tick();
        pulse_finish();
        check("t4_err_count", err_count, 1);
        check("t4_cmd_count", cmd_count, 1);
        check("t4_busy", seq_busy, 0);

        // Watchdog expiry after exactly TO wait cycles
        clear_status();
        fifo_q.push_back(32'h4000_3344);
        exp_w.push_back(16'h3344);
        wait_sig(0, 20, "t5_wstart");
        repeat (TO) tick();
        check("t5_busy_last_wait", seq_busy, 1);
        check("t5_timeout_pre", timeout_err, 0);
        tick();
        check("t5_busy_after", seq_busy, 0);
        check("t5_timeout", timeout_err, 1);
        check("t5_cmd_count", cmd_count, 0);
        fifo_q.push_back(32'hFFFF_FFFF);
        repeat (8) tick();
        check("t5_err_count", err_count, 1);
        clear_status();
        check("t5_clr_cmd", cmd_count, 0);
        check("t5_clr_err", err_count, 0);
        check("t5_clr_timeout", timeout_err, 0);

        // Completion in the expiry cycle wins
        fifo_q.push_back(32'h4000_0505);
        exp_w.push_back(16'h0505);
        wait_sig(0, 20, "t5b_wstart");
        repeat (TO) tick();
        pulse_finish();
        check("t5b_cmd_count", cmd_count, 1);
        check("t5b_timeout", timeout_err, 0);
        check("t5b_busy", seq_busy, 0);

        // Asynchronous reset during WAIT_R
        fifo_q.push_back(32'h8000_1111);
        exp_r.push_back(8'h11);
        wait_sig(1, 20, "t6_rstart");
        tick(); tick();
        check("t6_busy_pre", seq_busy, 1);
        rst = 1'b1;
        #1;
        check("t6_busy", seq_busy, 0);
        check("t6_addr", addr_byte, 0);
        check("t6_cmd_count", cmd_count, 0);
        check("t6_rstart", ReadByteStart, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_idle_busy", seq_busy, 0);
            check("t6_idle_rd_en", cmd_fifo_rd_en, 0);
        end
        itf_sel = 1'b1;
        fifo_q.push_back(32'h4000_0909);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t6_itf_no_fetch", cmd_fifo_rd_en, 0);
        end
        itf_sel = 1'b0;
        exp_w.push_back(16'h0909);
        wait_sig(0, 20, "t6_wstart");
        tick();
        pulse_finish();
        check("t6_cmd_after", cmd_count, 1);

        repeat (3) tick();
        check("exp_w_drained", exp_w.size(), 0);
        check("exp_r_drained", exp_r.size(), 0);
        check("exp_rb_drained", exp_rb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
Upstream command stage for the I2C byte transmitter. Pops 32-bit command words from the host command FIFO (Opal Kelly pipe-in side). Decodes each word as an I2C write or read, issues one-cycle WriteByteStart/ReadByteStart pulses with stable addr_byte/data_byte, and waits for completion. Pushes read results into a read-back FIFO. Provides a watchdog, command/error counters and status for wire-out.

Parameters:
TIMEOUT_CYCLES, 1048576, max cycles spent waiting for completion of one command before abort
CNT_W, 16, width of the completed-command counter

Ports:
CLK  in  1  process clock, shared with the I2C transmitter
rst  in  1  asynchronous, active-high reset
enable  in  1  level; permits fetching new commands
itf_sel  in  1  interface select; 0 = I2C; fetch only when 0
clr_status  in  1  one-cycle pulse; clears counters and sticky flags
cmd_fifo_dout  in  32  command word: [31:30] opcode (01 write, 10 read, else illegal), [29:16] ignored, [15:8] register address, [7:0] write data
cmd_fifo_empty  in  1  command FIFO empty
cmd_fifo_rd_en  out  1  one-cycle pop; dout valid on the following cycle
addr_byte  out  8  register address to the transmitter
data_byte  out  8  write data to the transmitter
WriteByteStart  out  1  one-cycle write start pulse
ReadByteStart  out  1  one-cycle read start pulse
i2c_w_finish  in  1  one-cycle write-done pulse from the transmitter
i2c_rd_data_reg  in  8  read byte from the transmitter
i2c_rd_valid_flag  in  1  one-cycle read-done pulse
rb_fifo_din  out  16  {addr, read data}
rb_fifo_wr_en  out  1  one-cycle push
rb_fifo_full  in  1  read-back FIFO full
seq_busy  out  1  high whenever state != IDLE
cmd_count  out  CNT_W  completed commands, wraps at 2^CNT_W
err_count  out  8  illegal opcodes, saturates at 255
timeout_err  out  1  sticky watchdog flag

Behaviour:
- All outputs are registered. Asynchronous reset clears every output to 0 and sets state to IDLE, including mid-command. An in-flight transmitter operation is not tracked after reset.
- States: IDLE, FETCH, DECODE, ISSUE_W, WAIT_W, ISSUE_R, WAIT_R, PUSH.
- IDLE -> FETCH when enable & ~itf_sel & ~cmd_fifo_empty. cmd_fifo_rd_en is high for exactly one cycle, in FETCH.
- FETCH -> DECODE. In DECODE, the word is latched from cmd_fifo_dout. The opcode selects the next state:
  - 01 -> ISSUE_W
  - 10 -> ISSUE_R
  - otherwise err_count increments (saturating) and the FSM returns to IDLE with no start pulse.
- ISSUE_W/ISSUE_R: addr_byte and data_byte are updated, and the matching start pulse is high for this one cycle only. Latency: start pulse is 2 cycles after rd_en. addr_byte and data_byte hold stable until the next DECODE. For reads, data_byte = 0.
- WAIT_W -> IDLE on i2c_w_finish; cmd_count increments.
- WAIT_R -> PUSH on i2c_rd_valid_flag; i2c_rd_data_reg is captured in that same cycle.
- PUSH: if ~rb_fifo_full, rb_fifo_wr_en pulses for one cycle with {addr, byte}, cmd_count increments, and the FSM goes to IDLE. If full, the FSM holds in PUSH indefinitely (no watchdog) and no data is lost.
- Watchdog: the counter clears on entry to ISSUE_W/ISSUE_R and counts in WAIT_W/WAIT_R. On reaching TIMEOUT_CYCLES-1: set timeout_err, return to IDLE, do not increment cmd_count.
- Completion pulse arriving in the same cycle as the timeout: completion wins.
- Minimum back-to-back spacing: IDLE is always visited for 1 cycle between commands.
- enable deasserted mid-command: the current command completes, then the FSM stays in IDLE.
- itf_sel is sampled only in IDLE. Changing it mid-command is illegal; the watchdog recovers.
- clr_status zeroes cmd_count, err_count and timeout_err. It does not change state. If clr_status coincides with an increment, the clear wins.
- Completion pulses arriving in IDLE/FETCH/DECODE are ignored.

Decomposition:
- Package i2c_seq_pkg holds:
  - opcode constants OP_WRITE=2'b01, OP_READ=2'b10
  - state encodings (3-bit)
  - command-word field positions
  - the read-back word layout
- One sub-module, i2c_seq_watchdog: clear, count-enable, TIMEOUT_CYCLES parameter, one-cycle expire output.

Test Plan:
- Push 0x4000_1A5C with enable=1, itf_sel=0 -> rd_en pulse, then 2 cycles later WriteByteStart=1 for 1 cycle with addr_byte=0x1A, data_byte=0x5C. After an i2c_w_finish pulse -> cmd_count=1, seq_busy falls.
- Push 0x8000_2300, respond with rd_valid_flag and rd_data_reg=0xC3 -> one rb_fifo_wr_en with din=0x23C3, cmd_count=1.
- Read completes while rb_fifo_full=1 for 10 cycles -> no wr_en while full. A single push of the correct word occurs 1 cycle after full falls.
- Push 0xC000_0000 then 0x4000_0102 -> err_count=1, no start pulse for the first word, write issued for the second, cmd_count=1.
- Write with no finish, TIMEOUT_CYCLES=16 -> timeout_err=1 after 16 wait cycles, FSM back in IDLE, next command processed. Then clr_status -> all counters/flags 0.
- Assert rst during WAIT_R -> all outputs 0 immediately. After release with FIFO empty: no activity. With itf_sel=1 and a non-empty FIFO: no rd_en.
